grad_step_update: RTL and testbench
===================================

Name: grad_step_update

Overview:
Iteration controller that sits directly downstream of the finite-difference gradient/step stage and closes the gradient-descent loop. It holds the current (a,b,c,d) point in Q8.8 and launches one gradient evaluation per iteration. It consumes the returned per-axis step diffs and objective value, then applies a saturating subtract to each parameter. It terminates on convergence, on iteration limit, on gradient-stage overflow, or on a wait timeout.

Parameters:
MAX_ITER, 16'd256, iteration limit; must be at least 1.
EPSILON, 16'h0001, Q8.8 convergence threshold; converged when |diff| <= EPSILON on all four axes.
WAIT_TIMEOUT, 16'd1024, maximum cycles spent waiting for grad_done before aborting.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin optimisation; sampled only in IDLE
a_init, b_init, c_init, d_init  in  16 each  signed Q8.8 starting point
grad_start  out  1  one-cycle launch pulse to gradient stage
grad_a, grad_b, grad_c, grad_d  out  16 each  signed Q8.8 current point driven to gradient stage
grad_done  in  1  one-cycle completion pulse from gradient stage
grad_value  in  32  signed Q24.8 objective value at the current point
a_diff, b_diff, c_diff, d_diff  in  16 each  signed Q8.8 step (learning rate × gradient)
grad_overflow  in  1  gradient-stage overflow; qualified by grad_done
a_out, b_out, c_out, d_out  out  16 each  final or current point (same registers as grad_*)
value_out  out  32  last objective value latched
iter_count  out  16  completed update iterations
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse on termination
converged  out  1  sticky until next start: convergence termination
sat_flag  out  1  sticky until next start: any parameter saturated
err_overflow  out  1  sticky until next start: aborted on grad_overflow
err_timeout  out  1  sticky until next start: aborted on timeout

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs 0, including point, value_out, iter_count, all flags, grad_start and done. Internal wait counter cleared. Reset mid-operation abandons the run with no done pulse; the gradient stage is left to finish on its own.
- States: IDLE, LOAD, ISSUE, WAIT, UPDATE, CHECK, FINISH.
- IDLE: start=1 -> LOAD. start is ignored in every other state.
- LOAD: latch *_init into point registers; clear iter_count, flags and wait counter. -> ISSUE.
- ISSUE: grad_start=1 for exactly this cycle; wait counter cleared. Point registers are stable from here until UPDATE. -> WAIT.
- WAIT: increment wait counter each cycle.
  - grad_done=1 with grad_overflow=1: set err_overflow; point is not updated. -> FINISH.
  - grad_done=1 with grad_overflow=0: latch the four diffs and value_out <= grad_value. -> UPDATE.
  - Counter reaches WAIT_TIMEOUT with no grad_done: set err_timeout. -> FINISH.
  - grad_done and the timeout in the same cycle: grad_done wins.
- UPDATE: p_new = p - diff, computed in 17-bit signed arithmetic. Results > 32767 saturate to 16'h7FFF; results < -32768 saturate to 16'h8000; either case sets sat_flag. iter_count += 1. -> CHECK.
- CHECK: compute |diff| in 17 bits, so |16'h8000| = 32768 and never passes the threshold.
  - All four |diff| <= EPSILON: set converged. -> FINISH.
  - Otherwise iter_count == MAX_ITER: -> FINISH with converged=0.
  - Otherwise: -> ISSUE.
  - Convergence takes priority when both conditions hold.
- FINISH: done=1 for one cycle. -> IDLE. Outputs and flags hold until the next LOAD.
- Per-iteration latency: 3 cycles + gradient-stage latency. Point updates only in UPDATE.

Decomposition:
- Package grad_des_pkg holds:
  - Q8.8 constants Q88_MAX=16'h7FFF, Q88_MIN=16'h8000, Q88_ONE=16'h0100.
  - State encoding localparams (3-bit).
  - Q24.8 width constants.
- One sub-module, q88_sat_sub: 16-bit signed a - b with saturation and a sat output. Instantiated four times.

Test Plan:
- Basic convergence: stub returns a_diff=16'h0010 for 3 iterations then 0; other diffs always 0; a_init=16'h0100, b/c/d_init=0 -> done after iteration 4 with a_out=16'h00D0, iter_count=4, converged=1, sat_flag=0.
- Saturation: a_init=16'h7FF0, a_diff=16'h8000 -> a_out=16'h7FFF, sat_flag=1. |diff| 32768 > EPSILON, so iteration continues.
- Iteration limit: MAX_ITER=8, constant a_diff=16'h0004, a_init=0 -> done after iteration 8, a_out=16'hFFE0, converged=0, iter_count=8.
- Overflow abort: grad_overflow=1 with grad_done on iteration 2, a_diff=16'h0010, a_init=16'h0100 -> done, err_overflow=1, a_out=16'h00F0, iter_count=1.
- Timeout: stub never asserts grad_done, WAIT_TIMEOUT=16 -> done pulse within 18 cycles of grad_start, err_timeout=1, iter_count=0.
- Reset and start handling:
  - start pulsed during WAIT: ignored.
  - rst=1 during WAIT: busy=0 and all outputs 0 on the next cycle, no done pulse.
  - A subsequent start runs the basic-convergence case correctly.

Source files
------------

// File: rtl/grad_step_update_pkg.sv
// Shared constants, state encoding and helpers for the gradient-descent
// iteration controller and its saturating subtractor.
package grad_des_pkg;

   // Q8.8 fixed-point constants
   localparam int          Q88_W   = 16;
   localparam logic [15:0] Q88_MAX = 16'h7FFF;
   localparam logic [15:0] Q88_MIN = 16'h8000;
   localparam logic [15:0] Q88_ONE = 16'h0100;

   // Q24.8 objective value format
   localparam int Q24_8_W    = 32;
   localparam int Q24_8_FRAC = 8;

   // Controller state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_UPDATE = 3'd4;
   localparam logic [2:0] ST_CHECK  = 3'd5;
   localparam logic [2:0] ST_FINISH = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_LOAD   = ST_LOAD,
      S_ISSUE  = ST_ISSUE,
      S_WAIT   = ST_WAIT,
      S_UPDATE = ST_UPDATE,
      S_CHECK  = ST_CHECK,
      S_FINISH = ST_FINISH
   } state_t;

   // Magnitude of a Q8.8 value in 17 bits, so |16'h8000| is 32768 rather than wrapping.
   function automatic logic [16:0] abs17(input logic [15:0] v);
      logic [16:0] r;
      if (v[15]) begin
         r = 17'd0 - {1'b1, v};
      end else begin
         r = {1'b0, v};
      end
      return r;
   endfunction

endpackage

// File: rtl/grad_step_update_if.sv
// Handshake and data bundle between the iteration controller (master)
// and the finite-difference gradient stage (slave).
interface grad_step_update_if;
   import grad_des_pkg::*;

   logic                grad_start;
   logic [Q88_W-1:0]    grad_a;
   logic [Q88_W-1:0]    grad_b;
   logic [Q88_W-1:0]    grad_c;
   logic [Q88_W-1:0]    grad_d;
   logic                grad_done;
   logic [Q24_8_W-1:0]  grad_value;
   logic [Q88_W-1:0]    a_diff;
   logic [Q88_W-1:0]    b_diff;
   logic [Q88_W-1:0]    c_diff;
   logic [Q88_W-1:0]    d_diff;
   logic                grad_overflow;

   modport master (
      output grad_start, grad_a, grad_b, grad_c, grad_d,
      input  grad_done, grad_value, a_diff, b_diff, c_diff, d_diff, grad_overflow
   );

   modport slave (
      input  grad_start, grad_a, grad_b, grad_c, grad_d,
      output grad_done, grad_value, a_diff, b_diff, c_diff, d_diff, grad_overflow
   );

endinterface

// File: rtl/grad_step_update_sat_sub.sv
// Q8.8 signed subtract y = a - b with saturation to the Q8.8 range.
module q88_sat_sub
   import grad_des_pkg::*;
(
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_y,
   output logic        o_sat
);

   logic [16:0] w_diff;

   // 17-bit difference; the top two bits disagreeing means the result left the 16-bit range
   always_comb begin
      w_diff = {i_a[15], i_a} - {i_b[15], i_b};
      o_y    = w_diff[15:0];
      o_sat  = 1'b0;
      case (w_diff[16:15])
         2'b01: begin
            o_y   = Q88_MAX;
            o_sat = 1'b1;
         end
         2'b10: begin
            o_y   = Q88_MIN;
            o_sat = 1'b1;
         end
         default: begin
            o_y   = w_diff[15:0];
            o_sat = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/grad_step_update.sv
// Gradient-descent iteration controller: launches one gradient evaluation per
// iteration, applies saturating steps to the (a,b,c,d) point and terminates on
// convergence, iteration limit, gradient-stage overflow or wait timeout.
module grad_step_update
   import grad_des_pkg::*;
#(
   parameter logic [15:0] MAX_ITER     = 16'd256,
   parameter logic [15:0] EPSILON      = 16'h0001,
   parameter logic [15:0] WAIT_TIMEOUT = 16'd1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [15:0]         a_init,
   input  logic [15:0]         b_init,
   input  logic [15:0]         c_init,
   input  logic [15:0]         d_init,
   grad_step_update_if.master  gif,
   output logic [15:0]         a_out,
   output logic [15:0]         b_out,
   output logic [15:0]         c_out,
   output logic [15:0]         d_out,
   output logic [Q24_8_W-1:0]  value_out,
   output logic [15:0]         iter_count,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic                sat_flag,
   output logic                err_overflow,
   output logic                err_timeout
);

   state_t r_state, w_state_next;

   logic [15:0] r_pa, r_pb, r_pc, r_pd;
   logic [15:0] r_da, r_db, r_dc, r_dd;
   logic [Q24_8_W-1:0] r_value;
   logic [15:0] r_iter, r_wait_cnt;
   logic r_busy, r_done, r_grad_start;
   logic r_conv, r_sat, r_eovf, r_eto;

   logic [15:0] w_na, w_nb, w_nc, w_nd;
   logic w_sat_a, w_sat_b, w_sat_c, w_sat_d;
   logic [15:0] w_wait_inc;
   logic w_timeout, w_all_small, w_iter_limit;

   q88_sat_sub u_sub_a (.i_a(r_pa), .i_b(r_da), .o_y(w_na), .o_sat(w_sat_a));
   q88_sat_sub u_sub_b (.i_a(r_pb), .i_b(r_db), .o_y(w_nb), .o_sat(w_sat_b));
   q88_sat_sub u_sub_c (.i_a(r_pc), .i_b(r_dc), .o_y(w_nc), .o_sat(w_sat_c));
   q88_sat_sub u_sub_d (.i_a(r_pd), .i_b(r_dd), .o_y(w_nd), .o_sat(w_sat_d));

   assign w_wait_inc   = r_wait_cnt + 16'd1;
   assign w_timeout    = (w_wait_inc >= WAIT_TIMEOUT);
   assign w_iter_limit = (r_iter == MAX_ITER);
   assign w_all_small  = (abs17(r_da) <= {1'b0, EPSILON}) && (abs17(r_db) <= {1'b0, EPSILON}) &&
                         (abs17(r_dc) <= {1'b0, EPSILON}) && (abs17(r_dd) <= {1'b0, EPSILON});

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state selection; grad_done beats timeout, convergence beats the iteration limit
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_LOAD;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_LOAD:   w_state_next = S_ISSUE;
         S_ISSUE:  w_state_next = S_WAIT;
         S_WAIT: begin
            if (gif.grad_done) begin
               if (gif.grad_overflow) begin
                  w_state_next = S_FINISH;
               end else begin
                  w_state_next = S_UPDATE;
               end
            end else if (w_timeout) begin
               w_state_next = S_FINISH;
            end else begin
               w_state_next = S_WAIT;
            end
         end
         S_UPDATE: w_state_next = S_CHECK;
         S_CHECK: begin
            if (w_all_small) begin
               w_state_next = S_FINISH;
            end else if (w_iter_limit) begin
               w_state_next = S_FINISH;
            end else begin
               w_state_next = S_ISSUE;
            end
         end
         S_FINISH: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Datapath and registered status outputs; pulses are aligned with the state they mark
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pa <= 16'd0; r_pb <= 16'd0; r_pc <= 16'd0; r_pd <= 16'd0;
         r_da <= 16'd0; r_db <= 16'd0; r_dc <= 16'd0; r_dd <= 16'd0;
         r_value      <= 32'd0;
         r_iter       <= 16'd0;
         r_wait_cnt   <= 16'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_grad_start <= 1'b0;
         r_conv       <= 1'b0;
         r_sat        <= 1'b0;
         r_eovf       <= 1'b0;
         r_eto        <= 1'b0;
      end else begin
         r_grad_start <= (w_state_next == S_ISSUE);
         r_done       <= (w_state_next == S_FINISH);
         r_busy       <= (w_state_next != S_IDLE);
         case (r_state)
            S_LOAD: begin
               r_pa <= a_init; r_pb <= b_init; r_pc <= c_init; r_pd <= d_init;
               r_iter     <= 16'd0;
               r_wait_cnt <= 16'd0;
               r_conv     <= 1'b0;
               r_sat      <= 1'b0;
               r_eovf     <= 1'b0;
               r_eto      <= 1'b0;
            end
            S_ISSUE: r_wait_cnt <= 16'd0;
            S_WAIT: begin
               r_wait_cnt <= w_wait_inc;
               if (gif.grad_done) begin
                  if (gif.grad_overflow) begin
                     r_eovf <= 1'b1;
                  end else begin
                     r_da <= gif.a_diff; r_db <= gif.b_diff;
                     r_dc <= gif.c_diff; r_dd <= gif.d_diff;
                     r_value <= gif.grad_value;
                  end
               end else if (w_timeout) begin
                  r_eto <= 1'b1;
               end
            end
            S_UPDATE: begin
               r_pa <= w_na; r_pb <= w_nb; r_pc <= w_nc; r_pd <= w_nd;
               r_sat  <= r_sat | w_sat_a | w_sat_b | w_sat_c | w_sat_d;
               r_iter <= r_iter + 16'd1;
            end
            S_CHECK: begin
               if (w_all_small) begin
                  r_conv <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign gif.grad_start = r_grad_start;
   assign gif.grad_a     = r_pa;
   assign gif.grad_b     = r_pb;
   assign gif.grad_c     = r_pc;
   assign gif.grad_d     = r_pd;
   assign a_out          = r_pa;
   assign b_out          = r_pb;
   assign c_out          = r_pc;
   assign d_out          = r_pd;
   assign value_out      = r_value;
   assign iter_count     = r_iter;
   assign busy           = r_busy;
   assign done           = r_done;
   assign converged      = r_conv;
   assign sat_flag       = r_sat;
   assign err_overflow   = r_eovf;
   assign err_timeout    = r_eto;

endmodule

// File: tb/tb_grad_step_update.sv
// Directed self-checking bench for grad_step_update with a table-driven
// gradient-stage stub. DUT built with MAX_ITER=8, WAIT_TIMEOUT=16.
module tb_grad_step_update;
   import grad_des_pkg::*;

   logic clk = 1'b0;
   logic rst, start;
   logic [15:0] a_init, b_init, c_init, d_init;
   logic [15:0] a_out, b_out, c_out, d_out, iter_count;
   logic [31:0] value_out;
   logic busy, done, converged, sat_flag, err_overflow, err_timeout;

   grad_step_update_if gif();

   grad_step_update #(.MAX_ITER(16'd8), .EPSILON(16'h0001), .WAIT_TIMEOUT(16'd16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
      .gif(gif),
      .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
      .value_out(value_out), .iter_count(iter_count), .busy(busy), .done(done),
      .converged(converged), .sat_flag(sat_flag),
      .err_overflow(err_overflow), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Gradient-stage stub configuration
   bit          stub_en  = 1'b0;
   int          stub_lat = 2;
   int          stub_calls = 0;
   logic [15:0] a_tab [0:15];
   logic        ovf_tab [0:15];
   logic [15:0] first_a;

   // Gradient-stage stub: answers each grad_start after stub_lat cycles
   initial begin
      gif.grad_done = 1'b0; gif.grad_overflow = 1'b0; gif.grad_value = 32'd0;
      gif.a_diff = 16'd0; gif.b_diff = 16'd0; gif.c_diff = 16'd0; gif.d_diff = 16'd0;
      forever begin
         @(posedge clk); #1;
         gif.grad_done = 1'b0;
         gif.grad_overflow = 1'b0;
         if (stub_en && gif.grad_start === 1'b1) begin
            int idx;
            idx = (stub_calls < 16) ? stub_calls : 15;
            if (stub_calls == 0) first_a = gif.grad_a;
            for (int k = 0; k < stub_lat; k++) @(posedge clk);
            #1;
            gif.grad_done     = 1'b1;
            gif.grad_overflow = ovf_tab[idx];
            gif.a_diff        = a_tab[idx];
            gif.grad_value    = 32'h0001_0000 + 32'(idx);
            stub_calls++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_tables(input logic [15:0] first3, input logic [15:0] rest);
      for (int i = 0; i < 16; i++) begin
         a_tab[i]   = (i < 3) ? first3 : rest;
         ovf_tab[i] = 1'b0;
      end
      stub_calls = 0;
      first_a    = 16'hDEAD;
   endtask

   task automatic launch(input logic [15:0] a0);
      a_init = a0; b_init = 16'd0; c_init = 16'd0; d_init = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (done === 1'b1) begin seen = 1'b1; break; end
         tick();
      end
      n_checks++;
      if (!seen) $display("FAIL %s_done_wait: done=0 after 1000 cycles, required 1", tag);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      a_init = 16'd0; b_init = 16'd0; c_init = 16'd0; d_init = 16'd0;
      tick(); tick();
      n_checks++;
      if ({busy, done, converged, sat_flag, err_overflow, err_timeout, gif.grad_start} !== 7'b0)
         $display("FAIL reset_flags: got %b, required 0000000",
                  {busy, done, converged, sat_flag, err_overflow, err_timeout, gif.grad_start});
      else n_pass++;
      n_checks++;
      if ({a_out, b_out, c_out, d_out, value_out, iter_count} !== 112'd0)
         $display("FAIL reset_data: a=%h b=%h c=%h d=%h val=%h it=%0d, required all 0",
                  a_out, b_out, c_out, d_out, value_out, iter_count);
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic check_basic_result(input string tag);
      n_checks++;
      if (a_out !== 16'h00D0) $display("FAIL %s_a_out: got %h, required 00d0", tag, a_out); else n_pass++;
      n_checks++;
      if (iter_count !== 16'd4) $display("FAIL %s_iter: got %0d, required 4", tag, iter_count); else n_pass++;
      n_checks++;
      if ({converged, sat_flag, err_overflow, err_timeout} !== 4'b1000)
         $display("FAIL %s_flags: got %b, required 1000", tag, {converged, sat_flag, err_overflow, err_timeout});
      else n_pass++;
   endtask

   task automatic test_basic_convergence();
      stub_en = 1'b1; stub_lat = 2;
      set_tables(16'h0010, 16'h0000);
      launch(16'h0100);
      wait_done("basic");
      check_basic_result("basic");
      n_checks++;
      if (value_out !== 32'h0001_0003) $display("FAIL basic_value: got %h, required 00010003", value_out); else n_pass++;
      n_checks++;
      if (first_a !== 16'h0100) $display("FAIL basic_grad_a: got %h, required 0100", first_a); else n_pass++;
      tick();
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL basic_done_pulse: done,busy=%b, required 00", {done, busy}); else n_pass++;
   endtask

   task automatic test_saturation();
      stub_en = 1'b1; stub_lat = 2;
      set_tables(16'h8000, 16'h8000);
      launch(16'h7FF0);
      wait_done("sat");
      n_checks++;
      if (a_out !== 16'h7FFF) $display("FAIL sat_a_out: got %h, required 7fff", a_out); else n_pass++;
      n_checks++;
      if ({converged, sat_flag} !== 2'b01) $display("FAIL sat_flags: conv,sat=%b, required 01", {converged, sat_flag}); else n_pass++;
      n_checks++;
      if (iter_count !== 16'd8) $display("FAIL sat_iter: got %0d, required 8", iter_count); else n_pass++;
      tick();
   endtask

   task automatic test_iter_limit();
      stub_en = 1'b1; stub_lat = 2;
      set_tables(16'h0004, 16'h0004);
      launch(16'h0000);
      wait_done("limit");
      n_checks++;
      if (a_out !== 16'hFFE0) $display("FAIL limit_a_out: got %h, required ffe0", a_out); else n_pass++;
      n_checks++;
      if (iter_count !== 16'd8) $display("FAIL limit_iter: got %0d, required 8", iter_count); else n_pass++;
      n_checks++;
      if ({converged, sat_flag} !== 2'b00) $display("FAIL limit_flags: conv,sat=%b, required 00", {converged, sat_flag}); else n_pass++;
      tick();
   endtask

   task automatic test_overflow();
      stub_en = 1'b1; stub_lat = 2;
      set_tables(16'h0010, 16'h0010);
      ovf_tab[1] = 1'b1;
      launch(16'h0100);
      wait_done("ovf");
      n_checks++;
      if (a_out !== 16'h00F0) $display("FAIL ovf_a_out: got %h, required 00f0", a_out); else n_pass++;
      n_checks++;
      if (iter_count !== 16'd1) $display("FAIL ovf_iter: got %0d, required 1", iter_count); else n_pass++;
      n_checks++;
      if ({converged, err_overflow, err_timeout} !== 3'b010)
         $display("FAIL ovf_flags: conv,eovf,eto=%b, required 010", {converged, err_overflow, err_timeout});
      else n_pass++;
      n_checks++;
      if (value_out !== 32'h0001_0000) $display("FAIL ovf_value: got %h, required 00010000", value_out); else n_pass++;
      tick();
   endtask

   task automatic test_timeout();
      int  cnt;
      bit  seen;
      stub_en = 1'b0;
      launch(16'h0100);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (gif.grad_start === 1'b1) begin seen = 1'b1; break; end
         tick();
      end
      n_checks++;
      if (!seen) $display("FAIL tmo_grad_start: grad_start=0 after 20 cycles, required 1"); else n_pass++;
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(); cnt++;
         if (done === 1'b1) begin seen = 1'b1; break; end
      end
      n_checks++;
      if (!seen || cnt < 16 || cnt > 18)
         $display("FAIL tmo_latency: done after %0d cycles (seen=%0d), required 16..18", cnt, seen);
      else n_pass++;
      n_checks++;
      if ({err_timeout, err_overflow, converged} !== 3'b100)
         $display("FAIL tmo_flags: eto,eovf,conv=%b, required 100", {err_timeout, err_overflow, converged});
      else n_pass++;
      n_checks++;
      if (iter_count !== 16'd0) $display("FAIL tmo_iter: got %0d, required 0", iter_count); else n_pass++;
      tick();
   endtask

   task automatic test_start_ignored();
      bit seen;
      stub_en = 1'b1; stub_lat = 6;
      set_tables(16'h0010, 16'h0000);
      launch(16'h0100);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (gif.grad_start === 1'b1) begin seen = 1'b1; break; end
         tick();
      end
      tick(); tick();
      a_init = 16'h0555;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      n_checks++;
      if (!seen || busy !== 1'b1) $display("FAIL ign_busy: seen=%0d busy=%b, required 1 1", seen, busy); else n_pass++;
      wait_done("ign");
      check_basic_result("ign");
      tick();
   endtask

   task automatic test_reset_mid();
      bit seen;
      stub_en = 1'b0;
      launch(16'h0100);
      for (int i = 0; i < 20; i++) begin
         if (gif.grad_start === 1'b1) break;
         tick();
      end
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({busy, done, gif.grad_start, a_out, iter_count, value_out} !== 67'd0)
         $display("FAIL rstmid_state: busy=%b done=%b a=%h it=%0d val=%h, required all 0",
                  busy, done, a_out, iter_count, value_out);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("FAIL rstmid_quiet: done/busy rose after reset, required 0"); else n_pass++;
   endtask

   task automatic test_rerun();
      stub_en = 1'b1; stub_lat = 3;
      set_tables(16'h0010, 16'h0000);
      launch(16'h0100);
      wait_done("rerun");
      check_basic_result("rerun");
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_convergence();
      test_saturation();
      test_iter_limit();
      test_overflow();
      test_timeout();
      test_start_ignored();
      test_reset_mid();
      test_rerun();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
